// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-high segment codes {g,f,e,d,c,b,a}
// for hex digits 0..F and the all-off pattern.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Entry n is the active-high code for hex digit n (F first in the literal).
    localparam logic [15:0][6:0] SEG_CODES = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_CODES[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high segment code, forced off when blanked.
// Zero latency; no flow control.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = blank ? SEG_OFF : hex_to_seg(nibble);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: snapshots value once per frame and scans digits.
// One cycle from prescaler tick to registered pins; free-running, no backpressure.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int PRESCALE   = 100000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  blank_lz,
    output logic [DIGITS-1:0]     anode,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_strobe
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int PRE_W = $clog2(PRESCALE);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    // Physical pin levels are logical levels XOR this polarity bit.
    localparam logic              POL        = (ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] ANODE_IDLE = {DIGITS{POL}};
    localparam logic [6:0]        SEG_IDLE   = SEG_OFF ^ {7{POL}};

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] snap_q, snap_d;
    logic                tick_d_q, tick_d_d;
    logic                frame_strobe_q, frame_strobe_d;
    logic [DIGITS-1:0]   anode_q, anode_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;

    logic                tick;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic                upper_zero;
    logic [DIGITS-1:0]   onehot;
    logic [6:0]          dec_seg;

    // Prescaler, digit index and frame snapshot.
    always_comb begin
        tick           = (pre_q == PRE_LAST);
        pre_d          = tick ? '0 : pre_q + PRE_W'(1);
        idx_d          = idx_q;
        snap_d         = snap_q;
        frame_strobe_d = 1'b0;
        tick_d_d       = tick;
        if (tick) begin
            if (idx_q == IDX_LAST) begin
                idx_d          = '0;
                snap_d         = value;
                frame_strobe_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Walk from the most significant digit down so upper_zero covers nibbles i..DIGITS-1.
    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        upper_zero = 1'b1;
        onehot     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (snap_q[4*i +: 4] == 4'h0);
            onehot[i]  = (idx_q == IDX_W'(i));
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = snap_q[4*i +: 4];
                cur_dp    = dp_mask[i];
                cur_blank = blank_lz && (i != 0) && upper_zero;
            end
        end
    end

    seg7_hex_decode u_hex_decode (
        .nibble (cur_nib),
        .blank  (cur_blank),
        .seg    (dec_seg)
    );

    always_comb begin
        anode_d = anode_q;
        seg_d   = seg_q;
        dp_d    = dp_q;
        if (tick_d_q) begin
            anode_d = onehot ^ ANODE_IDLE;
            seg_d   = dec_seg ^ {7{POL}};
            dp_d    = cur_dp ^ POL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q          <= '0;
            idx_q          <= IDX_LAST;
            snap_q         <= '0;
            tick_d_q       <= 1'b0;
            frame_strobe_q <= 1'b0;
            anode_q        <= ANODE_IDLE;
            seg_q          <= SEG_IDLE;
            dp_q           <= POL;
        end else begin
            pre_q          <= pre_d;
            idx_q          <= idx_d;
            snap_q         <= snap_d;
            tick_d_q       <= tick_d_d;
            frame_strobe_q <= frame_strobe_d;
            anode_q        <= anode_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
        end
    end

    assign anode        = anode_q;
    assign seg          = seg_q;
    assign dp           = dp_q;
    assign frame_strobe = frame_strobe_q;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed seven-segment display driver that sits downstream of the mod-N digit counter stage in the board I/O path. Holds a snapshot of a packed hex value, steps through the digits at a prescaled scan rate and drives one-hot digit anodes plus decoded segments. It is used to show register and PC contents on the board display.

## Interface
- DIGITS, 4: number of display digits, ≥2; index width $clog2(DIGITS)
- PRESCALE, 100000: clk cycles per digit slot, ≥2; prescaler width $clog2(PRESCALE)
- ACTIVE_LOW, 1: 1 means anode, seg and dp are driven low-true; 0 means high-true
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- value  in  4*DIGITS  packed hex nibbles; nibble i = digit i; digit 0 is rightmost/least significant
- dp_mask  in  DIGITS  bit i lights the decimal point of digit i
- blank_lz  in  1  1 = blank leading-zero digits
- anode  out  DIGITS  one-hot digit enable, registered
- seg  out  7  segments {g,f,e,d,c,b,a}, registered
- dp  out  1  decimal point, registered
- frame_strobe  out  1  one-cycle pulse at each frame start, registered

## Operation
- Prescaler `pre` counts 0..PRESCALE-1 and wraps. Combinational `tick` = (pre == PRESCALE-1).
- Digit index `idx` resets to DIGITS-1. On a tick edge:
  - if idx == DIGITS-1: idx←0, snap←value, frame_strobe←1
  - else: idx←idx+1
  - frame_strobe is 0 on every other edge.
- `snap` is the only source for displayed nibbles. A change on value mid-frame is invisible until the next wrap.
- Output stage is registered from tick_d (tick delayed one cycle). When tick_d is 1, it loads:
  - anode = one-hot(idx)
  - seg = decode(snap nibble idx), or all-off if blanked
  - dp = dp_mask[idx], sampled live
- dp_mask and blank_lz are sampled live, not snapshotted.
- Leading-zero blanking: digit i>0 is blanked when blank_lz=1 and snap nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked. A blanked digit keeps its anode active and honours dp.
- Hex decode, active-high: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- ACTIVE_LOW=1 inverts anode, seg and dp at the output registers.
- Reset values (asynchronous, logical):
  - pre=0, idx=DIGITS-1, snap=0, tick_d=0, frame_strobe=0
  - anode all inactive, seg all off, dp off
  - Physical levels when ACTIVE_LOW=1: anode all 1, seg=7F, dp=1.

## Timing
- After reset release, the first tick is at edge PRESCALE. At that edge idx wraps to 0, snap is loaded and frame_strobe=1.
- Outputs first show digit 0 after edge PRESCALE+1. Latency from tick to pins is one cycle.
- Each digit is held for exactly PRESCALE cycles. The frame period is DIGITS*PRESCALE cycles.
- frame_strobe is high for exactly one cycle per frame, including the first frame after reset.
- Reset asserted mid-frame blanks all outputs immediately, without waiting for clk. After release, the sequence restarts exactly as from power-up.

## Structure
- Shared package seg7_pkg holds:
  - the 16-entry segment code constant
  - SEG_OFF constant
  - function hex_to_seg(nibble)
- Sub-module seg7_hex_decode is combinational: nibble + blank → 7-bit active-high code. Polarity inversion stays in the top-level output registers.
- The prescaler, digit index and output registers live in the top level.

## Test plan
All scenarios use DIGITS=4, PRESCALE=4, ACTIVE_LOW=1, dp_mask=0, blank_lz=0 unless stated.
- Reset release with value=16'h1234 → anode=1111, seg=7F through edge 4. After edge 5: anode=1110, seg=19 ('4'). Every 4 cycles after that: 1101/30 ('3'), 1011/24 ('2'), 0111/79 ('1'), then back to 1110/19.
- Change value to 16'hABCD while anode=1101 → remaining digits still show '2','1'. Next frame shows D=21, C=46, b=03, A=08.
- blank_lz=1, value=16'h0005 → digits 3..1 show seg=7F with anodes still cycling; digit 0 shows 12. With value=0, digit 0 shows 40 and the rest stay blank.
- dp_mask=4'b0100 → dp=0 only while anode=1011; dp=1 otherwise.
- Free-run → frame_strobe is one cycle wide every 16 cycles, coincident with the edge where idx wraps.
- Assert reset asynchronously mid-digit → anode=1111, seg=7F, dp=1 before the next clk edge. After release, the waveform repeats scenario 1 exactly.
